prio_intr_ctrl: RTL and testbench

Parametrised, priority-based interrupt controller sitting between up to NUM_SRC peripheral interrupt lines and the processor. The processor programs it over a simple APB-style register port. It holds a programmable priority, enable and edge/level mode per source and latches pending interrupts. It presents the single highest-priority eligible source to the processor with a valid/ack/end-of-interrupt handshake.

---
 rtl/prio_intr_ctrl.sv | 162 ++++++++++++++++
 tb/tb_prio_intr_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_intr_ctrl.sv
// Priority interrupt controller: per-source priority/enable/mode registers, pending latch,
// combinational arbitration and a valid/ack/eoi presentation FSM behind a one-wait-state register port.
module prio_intr_ctrl #(
  parameter int NUM_SRC = 16,
  parameter int PRI_W   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              error,
  input  logic [NUM_SRC-1:0] int_in,
  output logic              irq_valid,
  output logic [ID_W-1:0]   irq_id,
  input  logic              irq_ack,
  input  logic              irq_eoi
);

  localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(8'h80);
  localparam logic [ADDR_W-1:0] A_MODE    = ADDR_W'(8'h81);
  localparam logic [ADDR_W-1:0] A_PENDING = ADDR_W'(8'h82);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(8'h83);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_SERVICE} state_t;

  state_t              state;
  logic [PRI_W-1:0]    prio_reg [NUM_SRC];
  logic [NUM_SRC-1:0]  en_reg, mode_reg, pend_edge, int_q;
  logic [NUM_SRC-1:0]  pending, eligible, edge_set, ack_clr, w1c_clr;
  logic [ID_W-1:0]     win_id;
  logic [PRI_W-1:0]    win_prio;
  logic                any_elig, cur_elig, ack_taken;
  logic                is_prio, acc_err, acc_start, wr_commit;
  logic [DATA_W-1:0]   rd_val, status_val;
  logic                unused_wdata;

  assign unused_wdata = ^wdata;

  // Register port decode
  assign is_prio   = addr < ADDR_W'(NUM_SRC);
  assign acc_err   = !(is_prio || addr == A_ENABLE || addr == A_MODE || addr == A_PENDING ||
                       (addr == A_STATUS && !write));
  assign acc_start = sel && enable && !ready;
  assign wr_commit = sel && enable && ready && write && !acc_err;

  always_comb begin
    status_val = '0;
    status_val[0] = irq_valid;
    status_val[ID_W:1] = irq_id;
    status_val[DATA_W-1] = (state == S_SERVICE);
  end

  always_comb begin
    rd_val = '0;
    if (is_prio) begin
      rd_val = DATA_W'(prio_reg[addr[ID_W-1:0]]);
    end else begin
      case (addr)
        A_ENABLE:  rd_val = DATA_W'(en_reg);
        A_MODE:    rd_val = DATA_W'(mode_reg);
        A_PENDING: rd_val = DATA_W'(pending);
        A_STATUS:  rd_val = status_val;
        default:   rd_val = '0;
      endcase
    end
  end

  // Level sources mirror the synchronised line; edge sources use the latched bit
  assign pending   = (pend_edge & mode_reg) | (int_q & ~mode_reg);
  assign edge_set  = int_in & ~int_q;
  assign ack_taken = (state == S_PRESENT) && irq_ack;
  assign ack_clr   = ack_taken ? (NUM_SRC'(1) << irq_id) : '0;
  assign w1c_clr   = (wr_commit && addr == A_PENDING) ? wdata[NUM_SRC-1:0] : '0;

  // Highest priority wins; strict compare keeps the lowest index on ties
  always_comb begin
    eligible = '0;
    win_id   = '0;
    win_prio = '0;
    any_elig = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending[i] && en_reg[i] && (prio_reg[i] != '0);
      if (eligible[i] && prio_reg[i] > win_prio) begin
        win_id   = ID_W'(i);
        win_prio = prio_reg[i];
        any_elig = 1'b1;
      end
    end
  end

  assign cur_elig = eligible[irq_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b0;
      rdata    <= '0;
      error    <= 1'b0;
      en_reg   <= '0;
      mode_reg <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio_reg[i] <= '0;
    end else begin
      ready <= acc_start;
      rdata <= (acc_start && !acc_err && !write) ? rd_val : '0;
      error <= acc_start && acc_err;
      if (wr_commit) begin
        if (is_prio)                prio_reg[addr[ID_W-1:0]] <= wdata[PRI_W-1:0];
        else if (addr == A_ENABLE)  en_reg   <= wdata[NUM_SRC-1:0];
        else if (addr == A_MODE)    mode_reg <= wdata[NUM_SRC-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_q     <= '0;
      pend_edge <= '0;
      state     <= S_IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      int_q     <= int_in;
      pend_edge <= ((pend_edge & ~(ack_clr | w1c_clr)) | edge_set) & mode_reg;
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            irq_id    <= win_id;
            irq_valid <= 1'b1;
            state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= S_SERVICE;
          end else if (!cur_elig) begin
            irq_valid <= 1'b0;
            state     <= S_IDLE;
          end else if (win_prio > prio_reg[irq_id]) begin
            irq_id <= win_id;
          end
        end
        S_SERVICE: begin
          irq_valid <= 1'b0;
          if (irq_eoi) state <= S_IDLE;
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_intr_ctrl.sv
// Bench for prio_intr_ctrl: register-port vector table, directed handshake scenarios,
// and a randomized run against a behavioural model of the interrupt rules.
module tb_prio_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0, enable = 1'b0, write = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, error;
  logic [31:0] rdata;
  logic [15:0] int_in = '0;
  logic        irq_valid;
  logic [3:0]  irq_id;
  logic        irq_ack = 1'b0, irq_eoi = 1'b0;

  int checks = 0;
  int failures = 0;

  prio_intr_ctrl dut (
    .clk(clk), .rst(rst), .sel(sel), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .error(error), .int_in(int_in),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack), .irq_eoi(irq_eoi)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
    bit          chk_rd;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [7:0] a, logic [31:0] d, logic [31:0] e, bit er, bit c);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.exp_rd = e; v.exp_err = er; v.chk_rd = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    int_in = '0; irq_ack = 0; irq_eoi = 0; sel = 0; enable = 0; write = 0;
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic bus_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
    bit ok;
    sel = 1; enable = 1; write = wr; addr = a; wdata = d;
    ok = 0; rd = '0; er = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ready) begin ok = 1; rd = rdata; er = error; break; end
    end
    tick();
    sel = 0; enable = 0; write = 0;
    if (!ok) check("bus_ready", 32'(ok), 32'd1);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd; logic er;
    bus_xfer(1'b1, a, d, rd, er);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    bus_xfer(1'b0, a, 32'h0, rd, er);
    check(name, rd, exp);
  endtask

  task automatic pulse_int(input int idx);
    int_in[idx] = 1'b1; tick(); int_in[idx] = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1; tick(); irq_ack = 0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1; tick(); irq_eoi = 0;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!irq_valid && k < 12) begin tick(); k++; end
    check({name, "_valid"}, 32'(irq_valid), 32'd1);
  endtask

  // Behavioural model of pending/arbitration/handshake rules
  bit   model_on = 0;
  int   m_prio [16];
  bit   m_en [16], m_mode [16], m_pend [16], m_intq [16];
  int   m_st;      // 0 idle, 1 presented, 2 in service
  bit   m_valid;
  int   m_id;

  task automatic model_step();
    bit el [16];
    int best = 0, bid = 0, ack_id = -1;
    logic [15:0] in_v = int_in;
    for (int n = 0; n < 16; n++) begin
      bit pe = m_mode[n] ? m_pend[n] : m_intq[n];
      el[n] = pe && m_en[n] && (m_prio[n] != 0);
      if (el[n] && m_prio[n] > best) begin best = m_prio[n]; bid = n; end
    end
    if (m_st == 0) begin
      if (best > 0) begin m_id = bid; m_valid = 1; m_st = 1; end
    end else if (m_st == 1) begin
      if (irq_ack) begin m_valid = 0; m_st = 2; ack_id = m_id; end
      else if (!el[m_id]) begin m_valid = 0; m_st = 0; end
      else if (best > m_prio[m_id]) m_id = bid;
    end else begin
      if (irq_eoi) m_st = 0;
    end
    for (int n = 0; n < 16; n++) begin
      if (m_mode[n]) begin
        if (in_v[n] && !m_intq[n]) m_pend[n] = 1;
        else if (n == ack_id) m_pend[n] = 0;
      end
      m_intq[n] = in_v[n];
    end
  endtask

  always @(posedge clk) if (model_on) model_step();

  initial begin
    vec_t vecs[$];
    logic [31:0] rd;
    logic er;
    bit seen;

    // Register port table
    for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 8'(i), 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h80, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h81, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h82, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h83, 0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h90, 0, 0, 1, 1));
    vecs.push_back(mk(0, 8'h10, 0, 0, 1, 1));
    vecs.push_back(mk(0, 8'h7f, 0, 0, 1, 1));
    vecs.push_back(mk(1, 8'h83, 32'hffff_ffff, 0, 1, 0));
    vecs.push_back(mk(1, 8'h40, 32'h1, 0, 1, 0));
    vecs.push_back(mk(1, 8'h03, 32'hffff_fff5, 0, 0, 0));
    vecs.push_back(mk(0, 8'h03, 0, 32'h5, 0, 1));
    vecs.push_back(mk(1, 8'h80, 32'hffff_0288, 0, 0, 0));
    vecs.push_back(mk(0, 8'h80, 0, 32'h288, 0, 1));
    vecs.push_back(mk(1, 8'h81, 32'h0000_0288, 0, 0, 0));
    vecs.push_back(mk(0, 8'h81, 0, 32'h288, 0, 1));
    vecs.push_back(mk(0, 8'h83, 0, 0, 0, 1));

    do_reset();
    check("rst_valid", 32'(irq_valid), 0);
    check("rst_id", 32'(irq_id), 0);
    check("rst_ready", 32'(ready), 0);
    foreach (vecs[i]) begin
      bus_xfer(vecs[i].wr, vecs[i].a, vecs[i].d, rd, er);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Tie on priority resolved by index, then lower priority
    do_reset();
    wr_reg(8'h03, 5); wr_reg(8'h07, 5); wr_reg(8'h09, 2);
    wr_reg(8'h80, 32'h288); wr_reg(8'h81, 32'h288);
    int_in = 16'h0288; tick(); int_in = '0;
    check("lat_valid_early", 32'(irq_valid), 0);
    tick();
    check("lat_valid", 32'(irq_valid), 1);
    check("tie_id3", 32'(irq_id), 3);
    do_ack();
    check("ack_drop", 32'(irq_valid), 0);
    rd_chk("status_service", 8'h83, 32'h8000_0006);
    do_eoi();
    check("eoi_next_early", 32'(irq_valid), 0);
    wait_valid("id7");
    check("tie_id7", 32'(irq_id), 7);
    do_ack(); do_eoi();
    wait_valid("id9");
    check("id9", 32'(irq_id), 9);
    do_ack(); do_eoi();
    tick(); tick(); tick();
    check("all_served", 32'(irq_valid), 0);

    // Pre-ack preemption
    do_reset();
    wr_reg(8'h04, 1); wr_reg(8'h0a, 6);
    wr_reg(8'h80, 32'h410); wr_reg(8'h81, 32'h410);
    pulse_int(4);
    wait_valid("pre4");
    check("pre_id4", 32'(irq_id), 4);
    int_in[10] = 1; tick(); int_in[10] = 0;
    check("pre_hold_valid", 32'(irq_valid), 1);
    tick();
    check("pre_keep_valid", 32'(irq_valid), 1);
    check("pre_id10", 32'(irq_id), 10);
    do_ack();
    rd_chk("pre_pending", 8'h82, 32'h0010);

    // Level source re-presents, then drops while presented
    do_reset();
    wr_reg(8'h02, 3); wr_reg(8'h80, 32'h4);
    int_in[2] = 1;
    wait_valid("lvl");
    check("lvl_id", 32'(irq_id), 2);
    do_ack(); do_eoi();
    wait_valid("lvl_re");
    check("lvl_re_id", 32'(irq_id), 2);
    int_in[2] = 0; tick(); tick();
    check("lvl_drop", 32'(irq_valid), 0);
    rd_chk("lvl_idle", 8'h83, 32'h4);

    // W1C colliding with a rising edge: set wins
    do_reset();
    wr_reg(8'h04, 2); wr_reg(8'h81, 32'h30);
    sel = 1; enable = 1; write = 1; addr = 8'h82; wdata = 32'h10;
    tick();
    check("w1c_ready", 32'(ready), 1);
    int_in[4] = 1;
    tick();
    sel = 0; enable = 0; write = 0;
    rd_chk("w1c_set_wins", 8'h82, 32'h10);
    wr_reg(8'h82, 32'h10);
    rd_chk("w1c_clears", 8'h82, 32'h0);
    int_in[4] = 0;
    wr_reg(8'h80, 32'h20);
    pulse_int(5);
    seen = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (irq_valid) seen = 1; end
    check("prio0_never", 32'(seen), 0);
    rd_chk("prio0_pending", 8'h82, 32'h20);

    // Reset during service
    do_reset();
    wr_reg(8'h03, 5); wr_reg(8'h80, 32'h8); wr_reg(8'h81, 32'h8);
    pulse_int(3);
    wait_valid("rst_svc");
    do_ack();
    rst = 1; tick(); rst = 0;
    check("rst_svc_valid", 32'(irq_valid), 0);
    do_eoi(); tick();
    check("rst_eoi_valid", 32'(irq_valid), 0);
    rd_chk("rst_status", 8'h83, 0);
    rd_chk("rst_prio3", 8'h03, 0);
    rd_chk("rst_enable", 8'h80, 0);
    rd_chk("rst_mode", 8'h81, 0);
    rd_chk("rst_pending", 8'h82, 0);

    // Randomized run against the model
    do_reset();
    begin
      logic [15:0] en_v, mode_v;
      en_v = 16'($urandom) | 16'h0101;
      mode_v = 16'($urandom);
      for (int n = 0; n < 16; n++) begin
        m_prio[n] = (n % 5 == 0) ? 0 : int'($urandom_range(0, 15));
        wr_reg(8'(n), 32'(m_prio[n]));
        m_en[n] = en_v[n]; m_mode[n] = mode_v[n];
        m_pend[n] = 0; m_intq[n] = 0;
      end
      wr_reg(8'h80, 32'(en_v));
      wr_reg(8'h81, 32'(mode_v));
    end
    m_st = 0; m_valid = 0; m_id = 0;
    model_on = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      check("rnd_valid", 32'(irq_valid), 32'(m_valid));
      if (m_valid) check("rnd_id", 32'(irq_id), 32'(m_id));
      for (int n = 0; n < 16; n++)
        if ($urandom_range(0, 15) == 0) int_in[n] = ~int_in[n];
      irq_ack = ($urandom_range(0, 9) < 4);
      irq_eoi = ($urandom_range(0, 3) == 0);
    end
    model_on = 0;
    irq_ack = 0; irq_eoi = 0; int_in = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
